// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/add_1.sv
// One-bit full-adder cell; the only arithmetic in the serial adder datapath.
module add_1 (
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic cout,
  output logic sum
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one add_1 cell,
// with a carry flop closing the loop; result and done pulse after WIDTH cycles.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one operand bit per clock through the cell
// DONE   | result valid for one cycle; start here chains a new add
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // The MSB of the partial sum is always the current cell output, so only
  // WIDTH-1 bits need storing between edges.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_cell_sum;
  logic             w_cell_cout;
  logic [WIDTH-1:0] w_sum_next;

  add_1 u_add_1 (
    .cin  (r_carry),
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cout (w_cell_cout),
    .sum  (w_cell_sum)
  );

  assign w_accept   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_sum_next = {w_cell_sum, r_sum_sh};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = i_start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sh   <= i_a;
        r_b_sh   <= i_b;
        r_carry  <= i_cin;
        r_cnt    <= '0;
        r_sum_sh <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_carry  <= w_cell_cout;
        r_sum_sh <= w_sum_next[WIDTH-1:1];
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum  <= w_sum_next;
          r_cout <= w_cell_cout;
        end
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random adds
// compared against plain a+b+cin arithmetic.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns just after the accepting edge.
  task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Steps edges until done; while waiting, busy must be high and the old result held.
  task automatic wait_done(input logic [W:0] prev, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1) begin
        chk("busy_during_run", 64'(busy), 64'(1));
        chk("result_held", 64'({cout, sum}), 64'(prev));
      end
    end
    if (cyc >= 40) chk("done_timeout", 64'(done), 64'(1));
    chk("busy_with_done", 64'(busy), 64'(0));
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc);
    return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
  endfunction

  initial begin
    logic [W:0]   prev;
    logic [W:0]   exp9;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           cyc;
    int           pulses;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum",  64'(sum),  64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    prev = '0;

    // Normal add, carry ripple, maximum operands.
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin ra = 8'h5A; rb = 8'h3C; rc = 1'b0; end
        1:       begin ra = 8'hFF; rb = 8'h01; rc = 1'b0; end
        default: begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
      endcase
      exp9 = model(ra, rb, rc);
      go(ra, rb, rc);
      chk("busy_after_start", 64'(busy), 64'(1));
      wait_done(prev, cyc);
      chk("latency", 64'(cyc), 64'(W));
      chk("dir_result", 64'({cout, sum}), 64'(exp9));
      prev = exp9;
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
    end
    chk("case_5a_3c", 64'(model(8'h5A, 8'h3C, 1'b0)), 64'(9'h096));

    // Start while busy is ignored.
    go(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(prev, cyc);
    chk("ignored_latency", 64'(cyc + 3), 64'(W));
    chk("ignored_result", 64'({cout, sum}), 64'(9'h030));
    prev = 9'h030;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("no_second_op", 64'(pulses), 64'(0));

    // Back-to-back: start during the DONE cycle.
    go(8'h7F, 8'h01, 1'b0);
    wait_done(prev, cyc);
    chk("b2b_first", 64'({cout, sum}), 64'(9'h080));
    prev = 9'h080;
    go(8'h01, 8'h02, 1'b0);
    chk("b2b_busy_again", 64'(busy), 64'(1));
    chk("b2b_done_dropped", 64'(done), 64'(0));
    wait_done(prev, cyc);
    chk("b2b_gap", 64'(cyc + 1), 64'(W + 1));
    chk("b2b_second", 64'({cout, sum}), 64'(9'h003));
    prev = 9'h003;
    @(posedge clk); #1;

    // Reset mid-operation.
    go(8'h33, 8'h44, 1'b0);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_sum",  64'({cout, sum}), 64'(0));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("midrst_no_done", 64'(pulses), 64'(0));
    prev = '0;
    go(8'h03, 8'h04, 1'b0);
    wait_done(prev, cyc);
    chk("after_rst_result", 64'({cout, sum}), 64'(9'h007));
    prev = 9'h007;
    @(posedge clk); #1;

    // Random operands, optionally chained back-to-back.
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp9 = model(ra, rb, rc);
      go(ra, rb, rc);
      wait_done(prev, cyc);
      chk("rnd_latency", 64'(cyc), 64'(W));
      chk("rnd_result", 64'({cout, sum}), 64'(exp9));
      prev = exp9;
      if ($urandom_range(1, 0) == 0) begin
        @(posedge clk); #1;
        chk("rnd_done_pulse", 64'(done), 64'(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder. It sits directly upstream of the team's one-bit full-adder cell (`add_1`), which it drives one bit per clock, LSB first. Parallel operands are captured on a start handshake and shifted through the cell while a carry flip-flop closes the loop. The block then presents the full WIDTH-bit sum and carry-out together with a one-cycle `done` pulse. It trades WIDTH cycles of latency for a single adder cell and is used where area matters more than throughput.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..64.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; asynchronous, active-low.
- `start`  input  1  request to begin an addition; sampled on the rising edge of `clk`.
- `a`  input  WIDTH  operand A; captured when `start` is accepted.
- `b`  input  WIDTH  operand B; captured when `start` is accepted.
- `cin`  input  1  carry-in; captured when `start` is accepted.
- `busy`  output  1  high while an addition is in progress.
- `done`  output  1  one-cycle pulse; `sum` and `cout` are valid and newly updated.
- `sum`  output  WIDTH  result register; holds the last completed sum.
- `cout`  output  1  carry-out of the last completed addition.

## Operation
- State machine:
  - States are IDLE, RUN and DONE.
  - Reset enters IDLE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE when the bit counter reaches WIDTH-1 on the current edge.
  - DONE→RUN if `start`=1; otherwise DONE→IDLE.
- Start acceptance:
  - `start` is accepted only in IDLE or DONE.
  - `start` in RUN is ignored; no queuing, and operands are not re-sampled.
- On accept:
  - `a` and `b` load into right-shift registers.
  - The carry flop loads `cin`.
  - The bit counter clears to 0.
  - The internal sum shift register clears.
- Each RUN edge:
  - The full-adder cell receives the current operand LSBs and the carry flop.
  - The cell's sum bit shifts into the MSB of the internal sum shift register.
  - The cell's cout loads into the carry flop.
  - Both operand registers shift right by 1.
  - The counter increments.
- On the final RUN edge (counter = WIDTH-1):
  - `sum` is loaded with the completed shift value, including the bit produced on that edge.
  - `cout` is loaded with the cell's carry-out.
  - The state enters DONE.
- `sum` and `cout` change only on completion edges. During RUN they hold the previous result.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1); no overflow flag.
- Bit counter width is max(1, $clog2(WIDTH)).
- Reset values:
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - State IDLE; counter, shift registers and carry flop all 0.
- Reset mid-operation:
  - The addition is aborted immediately (asynchronous); no `done` pulse is produced.
  - `sum` and `cout` return to 0.

## Timing
- Edge E0: `start` accepted. `busy`=1 from after E0.
- Edges E1..EWIDTH each process one bit.
  - EWIDTH is the final RUN edge.
- After EWIDTH: `busy`=0 and `done`=1 for exactly one cycle.
  - `done` deasserts after EWIDTH+1 unless a new result completes.
- Latency: start edge to `done` is WIDTH cycles.
- Throughput: back-to-back `start` asserted during DONE gives one result every WIDTH+1 cycles.
  - In this case `busy` drops for only the DONE cycle.
- `busy` and `done` are never high together.
- Outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `serial_adder_pkg`:
  - Holds the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - 2'd3 is illegal and recovers to IDLE.
- One sub-module: the existing one-bit full-adder cell `add_1`.
  - Instantiated once, with ports `cin`, `a`, `b` → `cout`, `sum`.
  - No other adder logic exists in this block.
- Everything else lives in a single sequential process plus next-state logic:
  - FSM, counter, operand shift registers, sum shift register and carry flop.

## Test plan
- Normal add, WIDTH=8: `a`=0x5A, `b`=0x3C, `cin`=0 → `sum`=0x96, `cout`=0.
  - `done` high exactly 8 cycles after the start edge.
  - `busy` high for 8 cycles.
- Carry ripple, WIDTH=8: `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
- Maximum operands, WIDTH=8: `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- Start while busy:
  - Start 0x10+0x20.
  - At cycle 3, assert `start` with `a`=0xAA, `b`=0x55.
  - → single `done` with `sum`=0x30.
  - → no second operation.
- Back-to-back:
  - Assert `start` with 0x01+0x02 during the DONE cycle of a 0x7F+0x01 operation.
  - → `sum`=0x80, then `sum`=0x03.
  - → `done` pulses 9 cycles apart.
- Reset mid-operation:
  - Drop `rst_n` at cycle 4 of an addition.
  - → `busy`, `done`, `sum`, `cout` go to 0 immediately.
  - → no `done` is produced.
  - → the next `start` with 0x03+0x04 gives `sum`=0x07.
